// File: rtl/add_pipe_pkg.sv
// Shared types and helpers for the pipelined adder: per-result flags and
// the overflow rule selected by the sign input.
package add_pipe_pkg;

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
  } add_flags_t;

  // Signed rule ignores carry; unsigned rule is simply the carry out.
  function automatic logic add_overflow(input logic sign, input logic a_msb,
                                        input logic b_msb, input logic sum_msb,
                                        input logic carry);
    logic signed_ovf;
    signed_ovf = (a_msb == b_msb) && (sum_msb != a_msb);
    return sign ? signed_ovf : carry;
  endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// One CHUNK-wide slice of the adder with its own valid bit and elastic load.
// ADD_PIPE_SAT_EN enables output saturation in the last slice.
module add_pipe_stage
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8,
  parameter int IDX   = 0,
  parameter bit LAST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             take,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  input  logic             in_sign,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_carry,
  output logic             out_sign,
  output add_flags_t       out_flags
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d, a_q, a_d, b_q, b_d;
  logic             carry_q, carry_d, sign_q, sign_d;
  add_flags_t       flags_q, flags_d;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_raw, sum_fin;
  logic             ovf, ready, load;

  always_comb begin
    chunk_sum = {1'b0, in_a[IDX*CHUNK +: CHUNK]} + {1'b0, in_b[IDX*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, in_carry};
    sum_raw = in_sum;
    sum_raw[IDX*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    ovf = add_overflow(in_sign, in_a[WIDTH-1], in_b[WIDTH-1], sum_raw[WIDTH-1],
                       chunk_sum[CHUNK]);
    sum_fin = sum_raw;
`ifdef ADD_PIPE_SAT_EN
    // Saturate only once the full sum exists; earlier slices pass the raw partial sum.
    if (LAST && ovf) begin
      if (in_sign) sum_fin = {in_a[WIDTH-1], {(WIDTH-1){~in_a[WIDTH-1]}}};
      else         sum_fin = '1;
    end
`endif
    ready   = !valid_q || take;
    load    = in_valid && ready;
    valid_d = ready ? in_valid : valid_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    flags_d = flags_q;
    if (load) begin
      sum_d   = sum_fin;
      a_d     = in_a;
      b_d     = in_b;
      carry_d = chunk_sum[CHUNK];
      sign_d  = in_sign;
      flags_d = LAST ? '{cout: chunk_sum[CHUNK], overflow: ovf, zero: (sum_fin == '0)}
                     : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      flags_q <= '0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_carry = carry_q;
  assign out_sign  = sign_q;
  assign out_flags = flags_q;

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder, CHUNK bits per stage, valid/ready on both sides.
// Optional output saturation via ADD_PIPE_SAT_EN.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0 || STAGES < 1) begin : g_bad_cfg
    $error("add_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic [STAGES:0]  v_w;
  logic [STAGES:0]  rdy_w;
  logic [WIDTH-1:0] sum_w   [STAGES+1];
  logic [WIDTH-1:0] a_w     [STAGES+1];
  logic [WIDTH-1:0] b_w     [STAGES+1];
  logic             carry_w [STAGES+1];
  logic             sign_w  [STAGES+1];
  add_flags_t       flags_w [STAGES];

  assign v_w[0]     = in_valid;
  assign sum_w[0]   = '0;
  assign a_w[0]     = a;
  assign b_w[0]     = b;
  assign carry_w[0] = cin;
  assign sign_w[0]  = sign;
  assign rdy_w[STAGES] = out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // A stage can load if any stage from it onward is empty or the sink takes.
    assign rdy_w[gi] = out_ready || !(&v_w[STAGES:gi+1]);

    add_pipe_stage #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK),
      .IDX  (gi),
      .LAST (gi == STAGES - 1)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (v_w[gi]),
      .take     (rdy_w[gi+1]),
      .in_sum   (sum_w[gi]),
      .in_a     (a_w[gi]),
      .in_b     (b_w[gi]),
      .in_carry (carry_w[gi]),
      .in_sign  (sign_w[gi]),
      .out_valid(v_w[gi+1]),
      .out_sum  (sum_w[gi+1]),
      .out_a    (a_w[gi+1]),
      .out_b    (b_w[gi+1]),
      .out_carry(carry_w[gi+1]),
      .out_sign (sign_w[gi+1]),
      .out_flags(flags_w[gi])
    );

    if (gi != STAGES - 1) begin : g_mid
      logic unused_flags;
      assign unused_flags = ^flags_w[gi];
    end
  end

  logic unused_tail;
  assign unused_tail = ^{a_w[STAGES], b_w[STAGES], carry_w[STAGES], sign_w[STAGES]};

  assign in_ready  = rdy_w[0];
  assign out_valid = v_w[STAGES];
  assign out       = sum_w[STAGES];
  assign cout      = flags_w[STAGES-1].cout;
  assign overflow  = flags_w[STAGES-1].overflow;
  assign zero      = flags_w[STAGES-1].zero;

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe (WIDTH=16, CHUNK=8); honours ADD_PIPE_SAT_EN.
module tb_add_pipe;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         ov;
    logic         z;
  } res_t;

  logic         clk, rst, in_valid, in_ready, cin, sign;
  logic         out_valid, out_ready, cout, overflow, zero;
  logic [W-1:0] a, b, out;

  res_t exp_q[$];
  res_t got_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  add_pipe #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sign(sign), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .cout(cout), .overflow(overflow), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sg);
    res_t r;
    logic [W:0] raw;
    raw  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.res = raw[W-1:0];
    r.c   = raw[W];
    r.ov  = sg ? ((x[W-1] == y[W-1]) && (raw[W-1] != x[W-1])) : raw[W];
`ifdef ADD_PIPE_SAT_EN
    if (r.ov) r.res = sg ? (x[W-1] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
`endif
    r.z = (r.res == '0);
    return r;
  endfunction

  // One clock: record handshakes mid-cycle, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sign));
    if (out_valid && out_ready) got_q.push_back({out, cout, overflow, zero});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    a    = W'($urandom);
    b    = W'($urandom);
    cin  = 1'($urandom);
    sign = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sign = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out, cout, overflow, zero} !== {1'b0, 16'h0, 3'b000}) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%b out=%h c=%b ov=%b z=%b, want all 0",
               out_valid, out, cout, overflow, zero);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[4] = '{16'h00FF, 16'h7FFF, 16'hFFFF, 16'h1234};
    logic [W-1:0] vb[4] = '{16'h0001, 16'h0001, 16'h0001, 16'h0F0F};
    logic         vc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic         vs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    res_t g, e;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i]; sign = vs[i];
      in_valid = 1'b1;
      lat = 0;
      do begin
        tick();
        in_valid = 1'b0;
        lat++;
      end while (!out_valid && lat < 10);
      n_cmp++;
      if (lat !== 2) begin
        n_bad++;
        $display("FAIL latency[%0d]: got %0d cycles want 2", i, lat);
      end
      tick();
      n_cmp++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
        n_bad++;
        $display("FAIL directed_count[%0d]: got %0d results want %0d", i,
                 got_q.size(), exp_q.size());
      end
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front();
        e = exp_q.pop_front();
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL directed[%0d]: got out=%h c=%b ov=%b z=%b want out=%h c=%b ov=%b z=%b",
                   i, g.res, g.c, g.ov, g.z, e.res, e.c, e.ov, e.z);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t g, e;
    int nv = 0, first = -1, last = -1, idx = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (t < 8) begin
        rand_ops();
        in_valid = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_in_ready[%0d]: got %b want 1", t, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        nv++;
        if (first < 0) first = t;
        last = t;
      end
    end
    n_cmp++;
    if (nv != 8 || last - first != 7) begin
      n_bad++;
      $display("FAIL b2b_run: got %0d valid cycles over span %0d want 8 over 8",
               nv, last - first + 1);
    end
    n_cmp++;
    if (got_q.size() != 8 || exp_q.size() != 8) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d results want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL b2b[%0d]: got %h/%b%b%b want %h/%b%b%b", idx,
                 g.res, g.c, g.ov, g.z, e.res, e.c, e.ov, e.z);
      end
      idx++;
    end
  endtask

  task automatic test_backpressure();
    res_t g, e;
    int acc = 0, idx = 0;
    logic took;
    out_ready = 1'b0;
    rand_ops();
    in_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      took = in_ready;
      tick();
      if (took) begin
        acc++;
        rand_ops();
      end
    end
    n_cmp++;
    if (acc !== 2 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_fill: got accepts=%0d in_ready=%b want 2 and 0", acc, in_ready);
    end
    for (int t = 0; t < 3; t++) begin
      n_cmp++;
      if (!out_valid || exp_q.size() == 0 ||
          {out, cout, overflow, zero} !== exp_q[0]) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b out=%h want head held", t, out_valid, out);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release_in_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_no_bubble: got out_valid=%b want 1", out_valid);
    end
    for (int t = 0; t < 5; t++) tick();
    n_cmp++;
    if (got_q.size() != 3 || exp_q.size() != 3) begin
      n_bad++;
      $display("FAIL bp_count: got %0d results want %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (g !== e) begin
        n_bad++;
        $display("FAIL bp_drain[%0d]: got %h/%b%b%b want %h/%b%b%b", idx,
                 g.res, g.c, g.ov, g.z, e.res, e.c, e.ov, e.z);
      end
      idx++;
    end
  endtask

  task automatic test_reset_flight();
    int nv = 0;
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      rand_ops();
      a[0] = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out, cout, overflow, zero} !== {1'b0, 16'h0, 3'b000}) begin
      n_bad++;
      $display("FAIL flight_reset_out: got valid=%b out=%h c=%b ov=%b z=%b, want all 0",
               out_valid, out, cout, overflow, zero);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flight_reset_in_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (out_valid) nv++;
    end
    n_cmp++;
    if (nv != 0 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL flight_stale: got %0d valid cycles, %0d results want 0", nv, got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
